// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - shared types, limits and bus helpers for pulse_gen_multi
package pulse_gen_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PWM    = 1'b1
  } wave_mode_e;

  localparam int WIDTH_MAX    = 32;
  localparam int CHANNELS_MAX = 16;

  // Low bit of channel ch in a packed CHANNELS*width bus.
  function automatic int slice_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/pulse_gen_channel.sv
// rtl/pulse_gen_channel.sv - one pulse channel: period counter, shadow/active P/D, tick and wave
// PULSE_GEN_ONESHOT_EN adds oneshot_i/done_o (single-period mode).
module pulse_gen_channel
  import pulse_gen_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] period_i,
  input  logic [WIDTH-1:0] duty_i,
`ifdef PULSE_GEN_ONESHOT_EN
  input  logic             oneshot_i,
  output logic             done_o,
`endif
  output logic             tick_o,
  output logic             wave_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] act_p_q, act_p_d, act_d_q, act_d_d;
  logic [WIDTH-1:0] shd_p_q, shd_p_d, shd_d_q, shd_d_d;
  logic             wave_q, wave_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             wrap;
  logic             oneshot;
  wave_mode_e       mode;

`ifdef PULSE_GEN_ONESHOT_EN
  assign oneshot = oneshot_i;
  assign done_o  = done_q;
`else
  assign oneshot = 1'b0;
`endif

  assign mode = wave_mode_e'(mode_i);
  assign wrap = (count_q == act_p_q);

  always_comb begin
    count_d = count_q;
    act_p_d = act_p_q;
    act_d_d = act_d_q;
    wave_d  = wave_q;
    tick_d  = 1'b0;
    done_d  = done_q;
    // shadow_d already carries the inputs when load coincides with an update
    shd_p_d = load_i ? period_i : shd_p_q;
    shd_d_d = load_i ? duty_i : shd_d_q;

    if (!en_i) begin
      count_d = '0;
      wave_d  = 1'b0;
      done_d  = 1'b0;
      act_p_d = shd_p_d;
      act_d_d = shd_d_d;
    end else if (done_q) begin
      count_d = '0;
      wave_d  = 1'b0;
    end else begin
      count_d = wrap ? '0 : count_q + ONE;
      tick_d  = wrap;
      if (mode == MODE_PWM) begin
        wave_d = (count_d < act_d_q);
      end else begin
        wave_d = wave_q ^ wrap;
      end
      if (wrap) begin
        act_p_d = shd_p_d;
        act_d_d = shd_d_d;
        if (oneshot) begin
          done_d = 1'b1;
          wave_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      act_p_q <= '0;
      act_d_q <= '0;
      shd_p_q <= '0;
      shd_d_q <= '0;
      wave_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      act_p_q <= act_p_d;
      act_d_q <= act_d_d;
      shd_p_q <= shd_p_d;
      shd_d_q <= shd_d_d;
      wave_q  <= wave_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign tick_o = tick_q;
  assign wave_o = wave_q;

endmodule

// File: rtl/pulse_gen_multi.sv
// rtl/pulse_gen_multi.sv - CHANNELS independent programmable pulse/PWM generators
// PULSE_GEN_ONESHOT_EN adds oneshot_i/done_o.
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [CHANNELS-1:0]       en_i,
  input  logic [CHANNELS-1:0]       mode_i,
  input  logic [CHANNELS-1:0]       load_i,
  input  logic [CHANNELS*WIDTH-1:0] period_i,
  input  logic [CHANNELS*WIDTH-1:0] duty_i,
`ifdef PULSE_GEN_ONESHOT_EN
  input  logic [CHANNELS-1:0]       oneshot_i,
  output logic [CHANNELS-1:0]       done_o,
`endif
  output logic [CHANNELS-1:0]       tick_o,
  output logic [CHANNELS-1:0]       wave_o
);

  if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("pulse_gen_multi: WIDTH out of range");
  end
  if (CHANNELS < 1 || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
    $error("pulse_gen_multi: CHANNELS out of range");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam int LSB = slice_lsb(c, WIDTH);

    pulse_gen_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .en_i     (en_i[c]),
      .mode_i   (mode_i[c]),
      .load_i   (load_i[c]),
      .period_i (period_i[LSB +: WIDTH]),
      .duty_i   (duty_i[LSB +: WIDTH]),
`ifdef PULSE_GEN_ONESHOT_EN
      .oneshot_i(oneshot_i[c]),
      .done_o   (done_o[c]),
`endif
      .tick_o   (tick_o[c]),
      .wave_o   (wave_o[c])
    );
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// tb/tb_pulse_gen_multi.sv - self-checking bench for pulse_gen_multi (WIDTH=8, CHANNELS=4)
module tb_pulse_gen_multi;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk_i = 1'b0;
  logic           reset_i = 1'b1;
  logic [N-1:0]   en = '0, mode = '0, load = '0, oneshot = '0;
  logic [N*W-1:0] period_bus = '0, duty_bus = '0;
  logic [N-1:0]   tick_o, wave_o, done_o;

  pulse_gen_multi #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .en_i     (en),
    .mode_i   (mode),
    .load_i   (load),
    .period_i (period_bus),
    .duty_i   (duty_bus),
`ifdef PULSE_GEN_ONESHOT_EN
    .oneshot_i(oneshot),
    .done_o   (done_o),
`endif
    .tick_o   (tick_o),
    .wave_o   (wave_o)
  );

`ifndef PULSE_GEN_ONESHOT_EN
  assign done_o = '0;
`endif

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: phase within current period, active/pending P and D per channel.
  int m_ph[N], m_ap[N], m_ad[N], m_sp[N], m_sd[N];
  bit m_tick[N], m_wave[N], m_done[N];
  bit m_valid = 0;
  int nxt;
  bit boundary, os;

  always @(posedge clk_i) begin
    if (reset_i) begin
      m_valid = 1;
      for (int c = 0; c < N; c++) begin
        m_ph[c] = 0; m_ap[c] = 0; m_ad[c] = 0; m_sp[c] = 0; m_sd[c] = 0;
        m_tick[c] = 0; m_wave[c] = 0; m_done[c] = 0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        if (load[c]) begin
          m_sp[c] = int'(period_bus[c*W +: W]);
          m_sd[c] = int'(duty_bus[c*W +: W]);
        end
        os = 0;
`ifdef PULSE_GEN_ONESHOT_EN
        os = oneshot[c];
`endif
        if (!en[c]) begin
          m_ph[c] = 0; m_tick[c] = 0; m_wave[c] = 0; m_done[c] = 0;
          m_ap[c] = m_sp[c]; m_ad[c] = m_sd[c];
        end else if (m_done[c]) begin
          m_ph[c] = 0; m_tick[c] = 0; m_wave[c] = 0;
        end else begin
          boundary = (m_ph[c] == m_ap[c]);
          nxt = boundary ? 0 : m_ph[c] + 1;
          m_tick[c] = boundary;
          if (mode[c]) m_wave[c] = (nxt < m_ad[c]);
          else if (boundary) m_wave[c] = !m_wave[c];
          if (boundary) begin
            m_ap[c] = m_sp[c]; m_ad[c] = m_sd[c];
            if (os) begin m_done[c] = 1; m_wave[c] = 0; end
          end
          m_ph[c] = nxt;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (m_valid) begin
      for (int c = 0; c < N; c++) begin
        chk($sformatf("model_tick[%0d]", c), int'(tick_o[c]), int'(m_tick[c]));
        chk($sformatf("model_wave[%0d]", c), int'(wave_o[c]), int'(m_wave[c]));
`ifdef PULSE_GEN_ONESHOT_EN
        chk($sformatf("model_done[%0d]", c), int'(done_o[c]), int'(m_done[c]));
`endif
      end
    end
  end

  int tcnt[N], wones[N];
  logic [31:0] whist;

  task automatic clr();
    for (int c = 0; c < N; c++) begin tcnt[c] = 0; wones[c] = 0; end
    whist = '0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      for (int c = 0; c < N; c++) begin
        tcnt[c] += int'(tick_o[c]);
        wones[c] += int'(wave_o[c]);
      end
      whist = {whist[30:0], wave_o[0]};
    end
  endtask

  task automatic prog(input int c, input int p, input int d);
    period_bus[c*W +: W] = W'(p);
    duty_bus[c*W +: W]   = W'(d);
    load[c] = 1'b1;
  endtask

  initial begin
    step(2);
    chk("reset_tick", int'(tick_o), 0);
    chk("reset_wave", int'(wave_o), 0);
    reset_i = 1'b0;

    // toggle P=3: ticks every 4, wave 4 high / 4 low
    prog(0, 3, 0); step(1); load = '0;
    en[0] = 1'b1; clr(); step(16);
    chk("toggle_ticks", tcnt[0], 4);
    chk("toggle_wave_hist", int'(whist[15:0]), 16'h1E1E);

    // reset mid-run
    reset_i = 1'b1; step(2);
    chk("midreset_tick", int'(tick_o), 0);
    chk("midreset_wave", int'(wave_o), 0);
    chk("midreset_done", int'(done_o), 0);
    reset_i = 1'b0; en[0] = 1'b0;
    prog(0, 3, 0); step(1); load = '0;
    en[0] = 1'b1; clr(); step(8);
    chk("after_reset_ticks", tcnt[0], 2);

    // PWM P=4 D=2, then D=0 and D=7
    en[0] = 1'b0; mode[0] = 1'b1; prog(0, 4, 2); step(1); load = '0;
    en[0] = 1'b1; clr(); step(10);
    chk("pwm_d2_hist", int'(whist[9:0]), 10'b1000110001);
    en[0] = 1'b0; prog(0, 4, 0); step(1); load = '0;
    en[0] = 1'b1; clr(); step(10);
    chk("pwm_d0_ones", wones[0], 0);
    en[0] = 1'b0; prog(0, 4, 7); step(1); load = '0;
    en[0] = 1'b1; clr(); step(10);
    chk("pwm_d7_ones", wones[0], 10);

    // reload P=9 -> P=2 at count 4, then load coincident with a wrap
    en[0] = 1'b0; mode[0] = 1'b0; prog(0, 9, 0); step(1); load = '0;
    en[0] = 1'b1; step(4);
    prog(0, 2, 0); step(1); load = '0;
    clr(); step(5);
    chk("reload_old_period_ticks", tcnt[0], 1);
    clr(); step(9);
    chk("reload_new_period_ticks", tcnt[0], 3);
    step(2);
    prog(0, 5, 0); clr(); step(1); load = '0;
    chk("coincide_wrap_tick", tcnt[0], 1);
    clr(); step(5);
    chk("coincide_no_early_tick", tcnt[0], 0);
    clr(); step(1);
    chk("coincide_new_p_tick", tcnt[0], 1);

    // independence P=0..3
    en = '0; mode = '0;
    for (int c = 0; c < N; c++) prog(c, c, 0);
    step(1); load = '0;
    en = '1; clr(); step(12);
    chk("indep_ch0", tcnt[0], 12);
    chk("indep_ch1", tcnt[1], 6);
    chk("indep_ch2", tcnt[2], 4);
    chk("indep_ch3", tcnt[3], 3);
    en[2] = 1'b0; clr(); step(12);
    chk("indep_off_ch0", tcnt[0], 12);
    chk("indep_off_ch1", tcnt[1], 6);
    chk("indep_off_ch2", tcnt[2], 0);
    chk("indep_off_ch3", tcnt[3], 3);

`ifdef PULSE_GEN_ONESHOT_EN
    en = '0; oneshot[0] = 1'b1; prog(0, 5, 0); step(1); load = '0;
    en[0] = 1'b1; clr(); step(6);
    chk("oneshot_tick", tcnt[0], 1);
    chk("oneshot_done", int'(done_o[0]), 1);
    clr(); step(10);
    chk("oneshot_hold_ticks", tcnt[0], 0);
    chk("oneshot_hold_done", int'(done_o[0]), 1);
    en[0] = 1'b0; step(1);
    chk("oneshot_rearm_done", int'(done_o[0]), 0);
    en[0] = 1'b1; clr(); step(6);
    chk("oneshot_rearm_tick", tcnt[0], 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
